// File: rtl/conv_rdy_ctrl.sv
// Ready/strobe sequencer for a convolution layer: counts MAC taps per neuron,
// neurons per plane and planes per layer, and emits delayed write strobes/addresses.
module conv_rdy_ctrl #(
  parameter int unsigned IN_CH    = 4,
  parameter int unsigned K        = 5,
  parameter int unsigned R        = 28,
  parameter int unsigned C        = 28,
  parameter int unsigned OUT_CH   = 1,
  parameter int unsigned PIPE_DLY = 2,
  parameter int unsigned ADDR_W   = 16,
  localparam int unsigned OC_W    = (OUT_CH > 1) ? $clog2(OUT_CH) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              abort,
  input  logic              tap_vld,
  output logic              neuron_rdy,
  output logic              write_rdy,
  output logic [ADDR_W-1:0] out_addr,
  output logic              plane_rdy,
  output logic              layer_done,
  output logic              busy,
  output logic [OC_W-1:0]   oc_idx
);

  localparam int unsigned TAPS  = ((IN_CH + 3) / 4) * K * K;
  localparam int unsigned PIX   = R * C;
  localparam int unsigned TAP_W = (TAPS > 1) ? $clog2(TAPS) : 1;
  localparam int unsigned PIX_W = (PIX > 1) ? $clog2(PIX) : 1;
  localparam int unsigned PW    = PIPE_DLY + 1;
  localparam logic [PW-1:0] LAST_BIT = PW'(1) << PIPE_DLY;

  if (PIPE_DLY > 15) begin : g_dly_chk
    $error("conv_rdy_ctrl: PIPE_DLY must be in 0..15");
  end
  if ((ADDR_W < 63) && ((64'(PIX) * 64'(OUT_CH)) > (64'd1 << ADDR_W))) begin : g_addr_chk
    $error("conv_rdy_ctrl: PIX*OUT_CH exceeds the out_addr range");
  end

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

  state_t            r_state, w_state_nxt;
  logic [TAP_W-1:0]  r_tap_cnt, w_tap_nxt;
  logic [PIX_W-1:0]  r_pix_cnt, w_pix_nxt;
  logic [OC_W-1:0]   r_oc_idx, w_oc_nxt;
  logic [ADDR_W-1:0] r_out_addr, w_addr_nxt;
  logic [PW-1:0]     r_pipe, w_pipe_nxt;
  logic              r_plane_rdy, w_plane_nxt;
  logic              r_layer_done, r_busy;
  logic              w_nr_nxt;
  logic              w_tap_last, w_pix_last, w_oc_last, w_pend;

  assign w_tap_last = (r_tap_cnt == TAP_W'(TAPS - 1));
  assign w_pix_last = (r_pix_cnt == PIX_W'(PIX - 1));
  assign w_oc_last  = (r_oc_idx == OC_W'(OUT_CH - 1));
  // Anything still travelling down the delay line besides the bit on write_rdy now.
  assign w_pend     = |(r_pipe & ~LAST_BIT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_tap_nxt   = r_tap_cnt;
    w_pix_nxt   = r_pix_cnt;
    w_oc_nxt    = r_oc_idx;
    w_addr_nxt  = r_pipe[PIPE_DLY] ? r_out_addr + ADDR_W'(1) : r_out_addr;
    w_nr_nxt    = 1'b0;
    w_plane_nxt = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_state_nxt = S_RUN;
          w_tap_nxt   = '0;
          w_pix_nxt   = '0;
          w_oc_nxt    = '0;
          w_addr_nxt  = '0;
        end
      end
      S_RUN: begin
        if (tap_vld) begin
          if (w_tap_last) begin
            w_tap_nxt = '0;
            w_nr_nxt  = 1'b1;
            if (w_pix_last) begin
              w_pix_nxt   = '0;
              w_plane_nxt = 1'b1;
              if (w_oc_last) begin
                w_oc_nxt    = '0;
                w_state_nxt = S_DRAIN;
              end else begin
                w_oc_nxt = r_oc_idx + OC_W'(1);
              end
            end else begin
              w_pix_nxt = r_pix_cnt + PIX_W'(1);
            end
          end else begin
            w_tap_nxt = r_tap_cnt + TAP_W'(1);
          end
        end
      end
      S_DRAIN: begin
        if (!w_pend) w_state_nxt = S_DONE;
      end
      S_DONE: begin
        w_state_nxt = S_IDLE;
        w_addr_nxt  = '0;
      end
      default: w_state_nxt = S_IDLE;
    endcase
    // Shift the completion into the delay line; the top bit becomes write_rdy.
    w_pipe_nxt = PW'({r_pipe, w_nr_nxt});
    if (abort) begin
      w_state_nxt = S_IDLE;
      w_tap_nxt   = '0;
      w_pix_nxt   = '0;
      w_oc_nxt    = '0;
      w_addr_nxt  = '0;
      w_plane_nxt = 1'b0;
      w_pipe_nxt  = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tap_cnt    <= '0;
      r_pix_cnt    <= '0;
      r_oc_idx     <= '0;
      r_out_addr   <= '0;
      r_pipe       <= '0;
      r_plane_rdy  <= 1'b0;
      r_layer_done <= 1'b0;
      r_busy       <= 1'b0;
    end else begin
      r_tap_cnt    <= w_tap_nxt;
      r_pix_cnt    <= w_pix_nxt;
      r_oc_idx     <= w_oc_nxt;
      r_out_addr   <= w_addr_nxt;
      r_pipe       <= w_pipe_nxt;
      r_plane_rdy  <= w_plane_nxt;
      r_layer_done <= (w_state_nxt == S_DONE);
      r_busy       <= (w_state_nxt == S_RUN) || (w_state_nxt == S_DRAIN);
    end
  end

  assign neuron_rdy = r_pipe[0];
  assign write_rdy  = r_pipe[PIPE_DLY];
  assign out_addr   = r_out_addr;
  assign plane_rdy  = r_plane_rdy;
  assign layer_done = r_layer_done;
  assign busy       = r_busy;
  assign oc_idx     = r_oc_idx;

endmodule

// File: doc/conv_rdy_ctrl.md
CONV_RDY_CTRL -- requirements
Module: conv_rdy_ctrl

Interface
REQ-001 SHALL have parameter IN_CH, default 4, meaning input channels; taps per neuron TAPS = ceil(IN_CH/4)*K*K.
REQ-002 SHALL have parameter K, default 5, meaning kernel side length.
REQ-003 SHALL have parameters R and C, default 28 each, meaning output plane rows and columns; PIX = R*C.
REQ-004 SHALL have parameter OUT_CH, default 1, meaning output planes per layer.
REQ-005 SHALL have parameter PIPE_DLY, default 2, range 0..15, meaning cycles from neuron_rdy to write_rdy.
REQ-006 SHALL have parameter ADDR_W, default 16, meaning out_addr width; PIX*OUT_CH SHALL be at most 2^ADDR_W, with an elaboration error otherwise.
REQ-007 SHALL have port clk, input, 1 bit: the single clock, rising edge.
REQ-008 SHALL have port rst_n, input, 1 bit: asynchronous active-low reset.
REQ-009 SHALL have port start, input, 1 bit: layer start pulse.
REQ-010 SHALL have port abort, input, 1 bit: synchronous cancel.
REQ-011 SHALL have port tap_vld, input, 1 bit: one MAC tap consumed this cycle.
REQ-012 SHALL have port neuron_rdy, output, 1 bit: accumulation of one neuron complete.
REQ-013 SHALL have port write_rdy, output, 1 bit: write strobe for the delayed result.
REQ-014 SHALL have port out_addr, output, ADDR_W bits: write address, valid with write_rdy.
REQ-015 SHALL have port plane_rdy, output, 1 bit: last neuron of an output plane done.
REQ-016 SHALL have port layer_done, output, 1 bit: all writes of the layer issued.
REQ-017 SHALL have port busy, output, 1 bit: high in RUN or DRAIN.
REQ-018 SHALL have port oc_idx, output, clog2(OUT_CH) bits (minimum 1): current output channel.

Function
REQ-019 FSM SHALL have states IDLE, RUN, DRAIN and DONE; all outputs SHALL be registered.
- IDLE->RUN on start.
- RUN->DRAIN after the final neuron of the final channel.
- DRAIN->DONE when the delay line is empty.
- DONE->IDLE unconditionally after 1 cycle.
REQ-020 In RUN, tap_cnt SHALL increment on tap_vld; at tap_cnt==TAPS-1 with tap_vld, tap_cnt SHALL wrap to 0 and neuron_rdy SHALL pulse high for 1 cycle on the next cycle.
REQ-021 pix_cnt SHALL increment on each neuron completion and wrap at PIX-1; on wrap, plane_rdy SHALL pulse coincident with that neuron_rdy and oc_idx SHALL increment on the same edge.
REQ-022 write_rdy SHALL equal neuron_rdy delayed exactly PIPE_DLY cycles; with PIPE_DLY=0 it SHALL be coincident with neuron_rdy.
REQ-023 out_addr SHALL equal the count of prior write_rdy pulses in the layer: 0 on the first write, incrementing by 1 after each write, and never wrapping within a legal layer.
REQ-024 layer_done SHALL pulse 1 cycle in DONE, i.e. 1 cycle after the last write_rdy.
REQ-025 tap_vld outside RUN SHALL be ignored, and start outside IDLE SHALL be ignored.
REQ-026 When tap_vld and start coincide in IDLE, the tap SHALL NOT be counted.
REQ-027 abort SHALL have priority over all other inputs in any state: next cycle IDLE, counters and delay line cleared, and no further neuron_rdy, write_rdy or layer_done.
REQ-028 Back-to-back neuron completions SHALL be supported when TAPS=1; every tap_vld cycle then yields a neuron_rdy.

Reset
REQ-029 While rst_n is low, the block SHALL be in IDLE, all counters SHALL be 0, the delay line SHALL be cleared, and all outputs SHALL be 0 (out_addr=0, oc_idx=0).
REQ-030 Reset asserted mid-layer SHALL take effect immediately; after release, the block SHALL require a new start.

Verification (IN_CH=8, K=3 -> TAPS=18; R=C=4 -> PIX=16; OUT_CH=2; PIPE_DLY=2)
REQ-031 Continuous tap_vld after start SHALL give neuron_rdy at cycles 18, 36, ...; write_rdy 2 cycles after each; out_addr 0..31; plane_rdy after the 16th and 32nd neurons; layer_done 1 cycle after the write with out_addr=31.
REQ-032 Gapped tap_vld (1 cycle on, 2 off) SHALL give a neuron_rdy after every 18 accepted taps only, with no change to the address sequence.
REQ-033 abort after 5 neurons SHALL give busy low the next cycle, no pending write_rdy, and a following start SHALL begin at out_addr=0 with oc_idx=0.
REQ-034 rst_n pulsed low mid-DRAIN SHALL give all outputs 0 immediately and no layer_done.
REQ-035 start held high during RUN, and tap_vld in IDLE, SHALL leave the counts unchanged.
REQ-036 TAPS=1, PIPE_DLY=0 (IN_CH=4, K=1) SHALL give neuron_rdy and write_rdy every tap_vld cycle, with out_addr stepping by 1 per cycle.
